elevator_scheduler: RTL and testbench

Request scheduler placed in front of the elevator floor-stepping FSM. It records call requests in a pending bitmap and picks the next target floor with a SCAN policy: it serves all requests in the current direction of travel before it reverses. It holds the car at each served floor for a programmable door dwell. The scheduler's `target_floor` output drives the elevator's `floor` input, and the elevator's current floor comes back as `cur_floor`.

---
 rtl/elevator_scheduler_pkg.sv | 23 ++
 rtl/elevator_scheduler_if.sv | 34 +++
 rtl/elevator_floor_picker.sv | 42 ++++
 rtl/elevator_scheduler.sv | 138 +++++++++++++
 tb/tb_elevator_scheduler.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/elevator_scheduler_pkg.sv
// ============================================================================
// Module      : elevator_pkg
// Description : Shared types and sizes for the elevator scheduler and car FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package elevator_pkg;

  localparam int FLOOR_W    = 3;
  localparam int NUM_FLOORS = 8;
  localparam int DWELL_W    = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/elevator_scheduler_if.sv
// ============================================================================
// Module      : elevator_scheduler_if
// Description : Request and car-control signals between a requester and the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface elevator_scheduler_if #(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
);

  logic                  req_valid;
  logic [FLOOR_W-1:0]    req_floor;
  logic [FLOOR_W-1:0]    cur_floor;
  logic [FLOOR_W-1:0]    target_floor;
  logic [NUM_FLOORS-1:0] pending;
  logic                  dir_up;
  logic                  door_open;
  logic                  busy;

  modport master (
    output req_valid, req_floor, cur_floor,
    input  target_floor, pending, dir_up, door_open, busy
  );

  modport slave (
    input  req_valid, req_floor, cur_floor,
    output target_floor, pending, dir_up, door_open, busy
  );

endinterface

`default_nettype wire

// File: rtl/elevator_floor_picker.sv
// ============================================================================
// Module      : elevator_floor_picker
// Description : Finds the nearest pending floor strictly above and strictly below.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module elevator_floor_picker #(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
  input  wire [NUM_FLOORS-1:0] pending,
  input  wire [FLOOR_W-1:0]    cur_floor,
  output logic                 up_found,
  output logic [FLOOR_W-1:0]   up_floor,
  output logic                 dn_found,
  output logic [FLOOR_W-1:0]   dn_floor
);

  // Scanning toward cur_floor lets the last hit be the nearest one.
  always_comb begin
    up_found = 1'b0;
    up_floor = '0;
    dn_found = 1'b0;
    dn_floor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (FLOOR_W'(i) > cur_floor)) begin
        up_found = 1'b1;
        up_floor = FLOOR_W'(i);
      end
    end
    for (int j = 0; j < NUM_FLOORS; j++) begin
      if (pending[j] && (FLOOR_W'(j) < cur_floor)) begin
        dn_found = 1'b1;
        dn_floor = FLOOR_W'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/elevator_scheduler.sv
// ============================================================================
// Module      : elevator_scheduler
// Description : SCAN request scheduler with door dwell, feeding the car FSM target.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module elevator_scheduler #(
  parameter int NUM_FLOORS   = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W      = elevator_pkg::FLOOR_W,
  parameter int DWELL_CYCLES = 4
) (
  input wire              clk,
  input wire              rst,
  elevator_scheduler_if.slave bus
);

  import elevator_pkg::*;

  localparam logic [DWELL_W-1:0] C_DWELL = DWELL_W'(DWELL_CYCLES);

  sched_state_t          r_state, w_state_nxt;
  logic [NUM_FLOORS-1:0] r_pending, w_pending_nxt, w_set_mask, w_clr_mask;
  logic [DWELL_W-1:0]    r_dwell, w_dwell_nxt;
  logic                  r_dir_up, w_dir_up_nxt;
  logic [FLOOR_W-1:0]    r_target, w_target_nxt;
  logic                  w_up_found, w_dn_found;
  logic [FLOOR_W-1:0]    w_up_floor, w_dn_floor;
  logic                  w_req_cur, w_at_stop, w_hold;

  elevator_floor_picker #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_picker (
    .pending   (r_pending),
    .cur_floor (bus.cur_floor),
    .up_found  (w_up_found),
    .up_floor  (w_up_floor),
    .dn_found  (w_dn_found),
    .dn_floor  (w_dn_floor)
  );

  assign w_req_cur = bus.req_valid && (bus.req_floor == bus.cur_floor);
  assign w_at_stop = r_pending[bus.cur_floor];
  assign w_hold    = (r_state == IDLE) || (r_state == DOOR);

  always_comb begin
    w_state_nxt  = r_state;
    w_dir_up_nxt = r_dir_up;
    w_dwell_nxt  = '0;
    w_set_mask   = '0;
    w_clr_mask   = '0;

    // A call for the floor the car is parked at opens the door instead of queuing.
    if (bus.req_valid && !(w_req_cur && w_hold)) begin
      w_set_mask[bus.req_floor] = 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (w_req_cur) begin
          w_state_nxt = DOOR;
          w_dwell_nxt = C_DWELL;
        end else if (w_up_found && r_dir_up) begin
          w_state_nxt = MOVE_UP;
        end else if (w_dn_found) begin
          w_state_nxt  = MOVE_DOWN;
          w_dir_up_nxt = 1'b0;
        end else if (w_up_found) begin
          w_state_nxt  = MOVE_UP;
          w_dir_up_nxt = 1'b1;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (w_at_stop) begin
          w_state_nxt = DOOR;
          w_dwell_nxt = C_DWELL;
          w_clr_mask[bus.cur_floor] = 1'b1;
        end else if ((r_state == MOVE_UP) ? !w_up_found : !w_dn_found) begin
          w_state_nxt = IDLE;
        end
      end
      DOOR: begin
        if (w_req_cur) begin
          w_dwell_nxt = C_DWELL;
        end else if (r_dwell > 1) begin
          w_dwell_nxt = r_dwell - 1'b1;
        end else if (r_dir_up && w_up_found) begin
          w_state_nxt = MOVE_UP;
        end else if (!r_dir_up && w_dn_found) begin
          w_state_nxt = MOVE_DOWN;
        end else if (w_up_found) begin
          w_state_nxt  = MOVE_UP;
          w_dir_up_nxt = 1'b1;
        end else if (w_dn_found) begin
          w_state_nxt  = MOVE_DOWN;
          w_dir_up_nxt = 1'b0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_pending_nxt = (r_pending | w_set_mask) & ~w_clr_mask;

    case (w_state_nxt)
      MOVE_UP:   w_target_nxt = w_up_floor;
      MOVE_DOWN: w_target_nxt = w_dn_floor;
      default:   w_target_nxt = bus.cur_floor;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_dwell   <= '0;
      r_dir_up  <= 1'b1;
      r_target  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_dwell   <= w_dwell_nxt;
      r_dir_up  <= w_dir_up_nxt;
      r_target  <= w_target_nxt;
    end
  end

  assign bus.target_floor = r_target;
  assign bus.pending      = r_pending;
  assign bus.dir_up       = r_dir_up;
  assign bus.door_open    = (r_state == DOOR);
  assign bus.busy         = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
// ============================================================================
// Module      : tb_elevator_scheduler
// Description : Directed self-checking bench for the SCAN elevator scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elevator_scheduler;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  elevator_scheduler_if #(.NUM_FLOORS(8), .FLOOR_W(3)) bus ();

  elevator_scheduler #(
    .NUM_FLOORS   (8),
    .FLOOR_W      (3),
    .DWELL_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] floor);
    bus.req_valid = 1'b1;
    bus.req_floor = floor;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic step_to(input logic [2:0] floor);
    bus.cur_floor = floor;
    tick();
  endtask

  // Call right after the DOOR entry edge: door holds three more cycles, then leaves.
  task automatic door_run(input string tag);
    repeat (3) tick();
    check({tag, "_door_last"}, 32'(bus.door_open), 32'd1);
    tick();
    check({tag, "_door_done"}, 32'(bus.door_open), 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_floor = '0;
    bus.cur_floor = '0;

    #12;
    check("rst_target",  32'(bus.target_floor), 32'd0);
    check("rst_pending", 32'(bus.pending),      32'h00);
    check("rst_dir",     32'(bus.dir_up),       32'd1);
    check("rst_door",    32'(bus.door_open),    32'd0);
    check("rst_busy",    32'(bus.busy),         32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Single call to floor 5 from floor 0
    req(3'd5);
    check("t1_pending", 32'(bus.pending), 32'h20);
    check("t1_idle",    32'(bus.busy),    32'd0);
    tick();
    check("t1_busy",    32'(bus.busy),         32'd1);
    check("t1_target",  32'(bus.target_floor), 32'd5);
    for (int f = 1; f <= 4; f++) step_to(3'(f));
    check("t1_target4", 32'(bus.target_floor), 32'd5);
    step_to(3'd5);
    check("t1_door",    32'(bus.door_open), 32'd1);
    check("t1_clear",   32'(bus.pending),   32'h00);
    door_run("t1");
    check("t1_idle_end", 32'(bus.busy), 32'd0);

    // Nearer call in the direction of travel is picked up
    bus.cur_floor = 3'd2;
    req(3'd6);
    tick();
    check("t2_target6", 32'(bus.target_floor), 32'd6);
    req(3'd4);
    check("t2_pending", 32'(bus.pending),      32'h50);
    check("t2_still6",  32'(bus.target_floor), 32'd6);
    tick();
    check("t2_target4", 32'(bus.target_floor), 32'd4);
    step_to(3'd3);
    step_to(3'd4);
    check("t2_door4",   32'(bus.door_open), 32'd1);
    check("t2_pend4",   32'(bus.pending),   32'h40);
    door_run("t2a");
    check("t2_resume",  32'(bus.target_floor), 32'd6);
    check("t2_dir",     32'(bus.dir_up),       32'd1);
    step_to(3'd5);
    step_to(3'd6);
    check("t2_door6",   32'(bus.door_open), 32'd1);
    door_run("t2b");
    check("t2_idle",    32'(bus.busy), 32'd0);

    // Calls both ways from floor 3: up first, then reverse
    bus.cur_floor = 3'd3;
    req(3'd6);
    req(3'd1);
    check("t3_first",   32'(bus.target_floor), 32'd6);
    check("t3_pending", 32'(bus.pending),      32'h42);
    step_to(3'd4);
    step_to(3'd5);
    step_to(3'd6);
    check("t3_pend6",   32'(bus.pending), 32'h02);
    door_run("t3a");
    check("t3_rev_dir", 32'(bus.dir_up),       32'd0);
    check("t3_rev_tgt", 32'(bus.target_floor), 32'd1);
    for (int f = 5; f >= 1; f--) step_to(3'(f));
    check("t3_door1",   32'(bus.door_open), 32'd1);
    check("t3_pend1",   32'(bus.pending),   32'h00);
    door_run("t3b");
    check("t3_idle",    32'(bus.busy), 32'd0);

    // Same-floor call reloads the dwell at its last cycle
    req(3'd1);
    check("t4_door",    32'(bus.door_open), 32'd1);
    check("t4_nopend",  32'(bus.pending),   32'h00);
    repeat (3) tick();
    req(3'd1);
    check("t4_reload",  32'(bus.door_open), 32'd1);
    check("t4_pend",    32'(bus.pending),   32'h00);
    door_run("t4");
    check("t4_idle",    32'(bus.busy), 32'd0);

    // Duplicate calls to floor 7
    req(3'd7);
    req(3'd7);
    check("t5_pending", 32'(bus.pending),      32'h80);
    check("t5_target",  32'(bus.target_floor), 32'd7);
    check("t5_dir",     32'(bus.dir_up),       32'd1);
    for (int f = 2; f <= 7; f++) step_to(3'(f));
    check("t5_door",    32'(bus.door_open), 32'd1);
    check("t5_clear",   32'(bus.pending),   32'h00);
    door_run("t5");
    check("t5_idle",    32'(bus.busy), 32'd0);

    // Asynchronous reset while moving down with three calls pending
    req(3'd2);
    req(3'd4);
    req(3'd0);
    check("t6_pending", 32'(bus.pending),      32'h15);
    check("t6_target",  32'(bus.target_floor), 32'd4);
    check("t6_dir",     32'(bus.dir_up),       32'd0);
    check("t6_busy",    32'(bus.busy),         32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_target",  32'(bus.target_floor), 32'd0);
    check("t6_rst_pending", 32'(bus.pending),      32'h00);
    check("t6_rst_dir",     32'(bus.dir_up),       32'd1);
    check("t6_rst_door",    32'(bus.door_open),    32'd0);
    check("t6_rst_busy",    32'(bus.busy),         32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("t6_after_busy",  32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
